// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the MIPS CPU memory-bus arbiter.
// Holds the arbiter state encoding, the port-owner encoding and the bus
// widths used by mips_bus_arbiter and anything that talks to its ports.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Purpose: shares one Avalon-style memory port between the fetch unit (read
//   only) and the load/store unit (read/write with byte enables).
// Latency: request in cycle N -> strobe in N+1; with no stall, accept in N+1,
//   read data in N+2, back in IDLE in N+3.
// Backpressure: a port's waitrequest is low only in its acceptance cycle;
//   mem_waitrequest stalls acceptance, and TIMEOUT stalls abort with bus_error.
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   i_*                 fetch requester (read only)
//   d_*                 data requester (read/write, byte-enabled)
//   mem_*               shared memory port, word-aligned address
//   bus_error           sticky stall-timeout flag, cleared only by reset
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter bit RR      = 1'b1,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_readdatavalid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              bus_error
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  owner_t            owner, rr_last, grant;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;
  logic [CW-1:0]     stall_cnt;
  logic              err_q;

  logic i_req, d_req, tie, busy, accept, timeout;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign tie     = i_req & d_req;
  assign busy    = (state == BUSY);
  assign accept  = busy & ~mem_waitrequest;
  // The last permitted stall cycle: counter has already seen TIMEOUT-1 stalls.
  assign timeout = busy & mem_waitrequest & (stall_cnt == CW'(TIMEOUT - 1));

  // Owner selection. The round-robin pointer only tracks tie-break grants, so
  // an uncontested grant in between does not disturb the alternation.
  always_comb begin
    grant = OWN_I;
    if (tie) begin
      if (RR) grant = (rr_last == OWN_D) ? OWN_I : OWN_D;
      else    grant = OWN_D;
    end else if (d_req) begin
      grant = OWN_D;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_req | d_req) state_nxt = BUSY;
      BUSY: begin
        if (accept)       state_nxt = cmd_write ? IDLE : RESP;
        else if (timeout) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_I;
      rr_last   <= OWN_D;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (i_req | d_req)) begin
        owner     <= grant;
        stall_cnt <= '0;
        if (tie) rr_last <= grant;
        if (grant == OWN_D) begin
          // A simultaneous read and write is treated as a write.
          cmd_write <= d_write;
          cmd_addr  <= {d_address[ADDR_W-1:2], 2'b00};
          cmd_wdata <= d_writedata;
          cmd_be    <= d_byteenable;
        end else begin
          cmd_write <= 1'b0;
          cmd_addr  <= {i_address[ADDR_W-1:2], 2'b00};
          cmd_wdata <= '0;
          cmd_be    <= '1;
        end
      end
      if (timeout)                          err_q     <= 1'b1;
      else if (busy && mem_waitrequest)     stall_cnt <= stall_cnt + CW'(1);
    end
  end

  // Memory side is driven purely from the latched command while BUSY.
  assign mem_read       = busy & ~cmd_write;
  assign mem_write      = busy & cmd_write;
  assign mem_address    = busy ? cmd_addr  : '0;
  assign mem_writedata  = busy ? cmd_wdata : '0;
  assign mem_byteenable = busy ? cmd_be    : '0;

  assign i_waitrequest = ~(accept & (owner == OWN_I));
  assign d_waitrequest = ~(accept & (owner == OWN_D));

  assign i_readdatavalid = (state == RESP) & (owner == OWN_I);
  assign d_readdatavalid = (state == RESP) & (owner == OWN_D);
  assign i_readdata      = i_readdatavalid ? mem_readdata : '0;
  assign d_readdata      = d_readdatavalid ? mem_readdata : '0;

  assign bus_error = err_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a round-robin instance with a small
// byte-enabled RAM, plus a fixed-priority instance used for the RR=0 case.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write;
  logic [31:0] i_address, d_address, d_writedata;
  logic [3:0]  d_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  logic [31:0] i_readdata, d_readdata, mem_address, mem_writedata;
  logic        mem_read, mem_write, bus_error;
  logic [3:0]  mem_byteenable;

  logic        fp_i_read, fp_d_read;
  logic [31:0] fp_mem_readdata;
  logic        fp_i_waitrequest, fp_i_readdatavalid, fp_d_waitrequest, fp_d_readdatavalid;
  logic [31:0] fp_i_readdata, fp_d_readdata, fp_mem_address, fp_mem_writedata;
  logic        fp_mem_read, fp_mem_write, fp_bus_error;
  logic [3:0]  fp_mem_byteenable;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.RR(1'b1), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .bus_error(bus_error)
  );

  mips_bus_arbiter #(.RR(1'b0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .reset(reset),
    .i_read(fp_i_read), .i_address(i_address), .i_waitrequest(fp_i_waitrequest),
    .i_readdata(fp_i_readdata), .i_readdatavalid(fp_i_readdatavalid),
    .d_read(fp_d_read), .d_write(1'b0), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(fp_d_waitrequest), .d_readdata(fp_d_readdata),
    .d_readdatavalid(fp_d_readdatavalid),
    .mem_address(fp_mem_address), .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_writedata(fp_mem_writedata), .mem_byteenable(fp_mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(fp_mem_readdata),
    .bus_error(fp_bus_error)
  );

  assign fp_mem_readdata = 32'h0;

  // 16-word RAM behind the round-robin instance, one-cycle read latency.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) ram[k] <= 32'h0;
      ram[0] <= 32'h2402_0005;
      ram[4] <= 32'h1111_0000;
      mem_readdata <= 32'h0;
    end else begin
      if (mem_write && !mem_waitrequest)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address[5:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
      if (mem_read && !mem_waitrequest) mem_readdata <= ram[mem_address[5:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", mem_read, mem_write); end
    checks++; if (mem_address !== 32'h0 || mem_writedata !== 32'h0) begin failures++; $display("FAIL reset_buses got=%h/%h exp=0/0", mem_address, mem_writedata); end
    checks++; if (mem_byteenable !== 4'h0) begin failures++; $display("FAIL reset_be got=%h exp=0", mem_byteenable); end
    checks++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait got=%b%b exp=11", i_waitrequest, d_waitrequest); end
    checks++; if (i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%b%b exp=00", i_readdatavalid, d_readdatavalid); end
    checks++; if (i_readdata !== 32'h0 || d_readdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", i_readdata, d_readdata); end
    checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error got=%b exp=0", bus_error); end
  endtask

  task automatic test_fetch();
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    #1;
    checks++; if (i_waitrequest !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL fetch_idle got wait=%b rd=%b exp wait=1 rd=0", i_waitrequest, mem_read); end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL fetch_strobe got=%b%b exp=10", mem_read, mem_write); end
    checks++; if (mem_address !== 32'hBFC0_0000 || mem_byteenable !== 4'hF) begin failures++; $display("FAIL fetch_bus got=%h/%h exp=bfc00000/f", mem_address, mem_byteenable); end
    checks++; if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1) begin failures++; $display("FAIL fetch_accept got=%b%b exp=01", i_waitrequest, d_waitrequest); end
    i_read = 1'b0;
    tick();
    checks++; if (i_readdatavalid !== 1'b1 || i_readdata !== 32'h2402_0005) begin failures++; $display("FAIL fetch_data got=%b/%h exp=1/24020005", i_readdatavalid, i_readdata); end
    checks++; if (d_readdatavalid !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL fetch_resp_other got rdv=%b rd=%b exp 0/0", d_readdatavalid, mem_read); end
    tick();
    checks++; if (i_readdatavalid !== 1'b0 || i_waitrequest !== 1'b1) begin failures++; $display("FAIL fetch_done got rdv=%b wait=%b exp 0/1", i_readdatavalid, i_waitrequest); end
  endtask

  task automatic test_tie_rr();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      i_read = 1'b1; i_address = 32'hBFC0_0000;
      d_read = 1'b1; d_address = 32'hBFC0_0010; d_byteenable = 4'hF;
      tick();
      // First tie after reset goes to fetch, the repeat goes to data.
      if (r == 0) begin
        checks++; if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1) begin failures++; $display("FAIL tie1_first got i=%b d=%b exp i=0 d=1", i_waitrequest, d_waitrequest); end
        i_read = 1'b0;
      end else begin
        checks++; if (d_waitrequest !== 1'b0 || i_waitrequest !== 1'b1) begin failures++; $display("FAIL tie2_first got i=%b d=%b exp i=1 d=0", i_waitrequest, d_waitrequest); end
        d_read = 1'b0;
      end
      tick();
      tick();
      tick();
      if (r == 0) begin
        checks++; if (d_waitrequest !== 1'b0 || mem_address !== 32'hBFC0_0010) begin failures++; $display("FAIL tie1_second got d=%b addr=%h exp 0/bfc00010", d_waitrequest, mem_address); end
        d_read = 1'b0;
        tick();
        checks++; if (d_readdatavalid !== 1'b1 || d_readdata !== 32'h1111_0000 || i_readdatavalid !== 1'b0) begin failures++; $display("FAIL tie1_data got %b/%h/%b exp 1/11110000/0", d_readdatavalid, d_readdata, i_readdatavalid); end
      end else begin
        checks++; if (i_waitrequest !== 1'b0 || mem_address !== 32'hBFC0_0000) begin failures++; $display("FAIL tie2_second got i=%b addr=%h exp 0/bfc00000", i_waitrequest, mem_address); end
        i_read = 1'b0;
        tick();
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    for (int r = 0; r < 2; r++) begin
      fp_i_read = 1'b1; fp_d_read = 1'b1;
      tick();
      checks++; if (fp_d_waitrequest !== 1'b0 || fp_i_waitrequest !== 1'b1) begin failures++; $display("FAIL fp_tie%0d got i=%b d=%b exp i=1 d=0", r, fp_i_waitrequest, fp_d_waitrequest); end
      fp_d_read = 1'b0;
      tick();
      tick();
      tick();
      checks++; if (fp_i_waitrequest !== 1'b0) begin failures++; $display("FAIL fp_second%0d got i=%b exp 0", r, fp_i_waitrequest); end
      fp_i_read = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_store();
    d_write = 1'b1; d_address = 32'hBFC0_0013; d_writedata = 32'h0000_2222; d_byteenable = 4'b0011;
    tick();
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || d_waitrequest !== 1'b0) begin failures++; $display("FAIL store_strobe got wr=%b rd=%b wait=%b exp 1/0/0", mem_write, mem_read, d_waitrequest); end
    checks++; if (mem_address !== 32'hBFC0_0010 || mem_byteenable !== 4'b0011 || mem_writedata !== 32'h0000_2222) begin failures++; $display("FAIL store_bus got %h/%h/%h exp bfc00010/3/00002222", mem_address, mem_byteenable, mem_writedata); end
    d_write = 1'b0;
    tick();
    checks++; if (mem_write !== 1'b0 || d_waitrequest !== 1'b1 || d_readdatavalid !== 1'b0) begin failures++; $display("FAIL store_done got wr=%b wait=%b rdv=%b exp 0/1/0", mem_write, d_waitrequest, d_readdatavalid); end
    d_read = 1'b1; d_address = 32'hBFC0_0010; d_byteenable = 4'hF;
    tick();
    d_read = 1'b0;
    tick();
    checks++; if (d_readdatavalid !== 1'b1 || d_readdata !== 32'h1111_2222) begin failures++; $display("FAIL store_readback got %b/%h exp 1/11112222", d_readdatavalid, d_readdata); end
    tick();
  endtask

  task automatic test_stall();
    d_read = 1'b1; d_address = 32'hBFC0_0001; d_byteenable = 4'hF;
    mem_waitrequest = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) mem_waitrequest = 1'b0;
      #1;
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'hBFC0_0000 || mem_byteenable !== 4'hF) begin failures++; $display("FAIL stall_hold%0d got rd=%b addr=%h be=%h exp 1/bfc00000/f", k, mem_read, mem_address, mem_byteenable); end
      checks++; if (d_waitrequest !== (k == 4 ? 1'b0 : 1'b1)) begin failures++; $display("FAIL stall_wait%0d got=%b exp=%b", k, d_waitrequest, (k == 4 ? 1'b0 : 1'b1)); end
      d_address = 32'h0;
    end
    d_read = 1'b0;
    tick();
    checks++; if (d_readdatavalid !== 1'b1 || d_readdata !== 32'h2402_0005) begin failures++; $display("FAIL stall_data got %b/%h exp 1/24020005", d_readdatavalid, d_readdata); end
    tick();
  endtask

  task automatic test_timeout();
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    mem_waitrequest = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (mem_read !== 1'b1 || i_waitrequest !== 1'b1 || bus_error !== 1'b0) begin failures++; $display("FAIL timeout_stall%0d got rd=%b wait=%b err=%b exp 1/1/0", k, mem_read, i_waitrequest, bus_error); end
    end
    i_read = 1'b0;
    tick();
    checks++; if (mem_read !== 1'b0 || bus_error !== 1'b1) begin failures++; $display("FAIL timeout_abort got rd=%b err=%b exp 0/1", mem_read, bus_error); end
    mem_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (i_readdatavalid !== 1'b0 || bus_error !== 1'b1) begin failures++; $display("FAIL timeout_after%0d got rdv=%b err=%b exp 0/1", k, i_readdatavalid, bus_error); end
    end
    do_reset();
    checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", bus_error); end
  endtask

  task automatic test_reset_in_resp();
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    tick();
    i_read = 1'b0;
    tick();
    checks++; if (i_readdatavalid !== 1'b1) begin failures++; $display("FAIL rstresp_setup got rdv=%b exp 1", i_readdatavalid); end
    reset = 1'b0;
    tick();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin failures++; $display("FAIL rstresp_outputs got %b%b%b%b exp 0000", mem_read, mem_write, i_readdatavalid, d_readdatavalid); end
    reset = 1'b1;
    tick();
    checks++; if (i_readdatavalid !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL rstresp_late got rdv=%b rd=%b exp 0/0", i_readdatavalid, mem_read); end
    // A fresh request must be picked up immediately, which only happens from IDLE.
    d_read = 1'b1; d_address = 32'hBFC0_0000;
    tick();
    checks++; if (mem_read !== 1'b1 || d_waitrequest !== 1'b0) begin failures++; $display("FAIL rstresp_idle got rd=%b wait=%b exp 1/0", mem_read, d_waitrequest); end
    d_read = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = 32'h0; d_address = 32'h0; d_writedata = 32'h0; d_byteenable = 4'h0;
    mem_waitrequest = 1'b0;
    fp_i_read = 1'b0; fp_d_read = 1'b0;
    test_reset();
    test_fetch();
    test_tie_rr();
    test_fixed_prio();
    test_store();
    test_stall();
    test_timeout();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter that shares the single Avalon-style memory port of `mips_cpu_bus` between the instruction-fetch unit (read-only) and the load/store unit (read/write, byte-enabled). It latches one requester's command, presents it to memory until accepted through `waitrequest`, and routes the one-cycle-latency read data back to the owning requester. It sits between the CPU core and the bus pins seen by the testbench RAM.

## Interface
- `RR`, 1, arbitration mode: 1 = round-robin on conflict, 0 = fixed data-port priority
- `TIMEOUT`, 1023, maximum consecutive cycles `mem_waitrequest` may stall one command before `bus_error`
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `i_read`  in  1  fetch request
- `i_address`  in  32  fetch byte address
- `i_waitrequest`  out  1  high until the fetch command is accepted by memory
- `i_readdata`  out  32  fetch data, valid with `i_readdatavalid`
- `i_readdatavalid`  out  1  one-cycle pulse
- `d_read`, `d_write`  in  1  data-port requests
- `d_address`  in  32  data byte address
- `d_writedata`  in  32  store data
- `d_byteenable`  in  4  store/load lanes
- `d_waitrequest`  out  1  high until the data command is accepted
- `d_readdata`  out  32  load data, valid with `d_readdatavalid`
- `d_readdatavalid`  out  1  one-cycle pulse
- `mem_address`  out  32  word-aligned address, bits [1:0] forced to 0
- `mem_read`, `mem_write`  out  1  memory strobes, never both high
- `mem_writedata`  out  32, `mem_byteenable`  out  4
- `mem_waitrequest`  in  1  memory stall
- `mem_readdata`  in  32  valid the cycle after a read is accepted
- `bus_error`  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any request, select owner, latch kind/address/writedata/byteenable into command registers, go BUSY. Fetch byteenable is latched as 4'b1111.
- Selection: only one requesting → that one. Both requesting: RR=1 grants the port not granted last (pointer resets to "data", so first tie goes to fetch); RR=0 always grants data.
- `d_read` and `d_write` both high: treated as write.
- BUSY: memory strobes and buses driven from command registers only; requester inputs ignored after latching. Acceptance = BUSY and `mem_waitrequest`=0. On acceptance the owner's waitrequest is low for that cycle only; write → IDLE, read → RESP.
- RESP: owner's readdatavalid=1, owner's readdata=`mem_readdata`; → IDLE. Non-owner readdatavalid stays 0.
- Waitrequest outputs are high in every cycle except the owner's acceptance cycle.
- Stall counter: counts BUSY cycles with `mem_waitrequest`=1. When it reaches `TIMEOUT`: drop strobes, set `bus_error`, → IDLE without handshake completion. The requester is not answered. `bus_error` clears only on reset.

## Timing
- Reset (`reset`=0 at edge): state IDLE, pending command discarded, `mem_read`=`mem_write`=0, `mem_address`/`mem_writedata`=0, `mem_byteenable`=0, both waitrequests=1, both readdatavalids=0, readdata outputs=0, `bus_error`=0, RR pointer=data. Applies mid-BUSY/RESP; no late readdatavalid.
- Request at cycle N in IDLE → strobe at N+1; with zero stall, acceptance at N+1. Read data is valid at N+2 and the arbiter is back in IDLE at N+3.
- Throughput without stall: one read per 3 cycles, one write per 2 cycles.
- Each stall cycle adds one cycle to acceptance.

## Structure
- Shared package `mips_bus_pkg`: state enum (IDLE/BUSY/RESP), owner enum (OWN_I/OWN_D), bus width constants.
- A single module is sufficient. No sub-module is needed.

## Test plan
- Fetch only: `i_address`=0xBFC00000, RAM word 0x24020005, no stall → `mem_read` at N+1, `i_readdatavalid` with 0x24020005 at N+2; `d_readdatavalid` stays 0.
- Tie, RR=1: both read at the same cycle after reset → fetch served first, data second. Repeat the tie → data served first. With RR=0, data is always served first.
- Store: `d_write`, address 0xBFC00013, data 0x00002222, byteenable 4'b0011 → `mem_address`=0xBFC00010, `mem_byteenable`=4'b0011. RAM low half is updated, and the next read returns 0x....2222.
- Stall: `mem_waitrequest` held 3 cycles → strobes and buses stable 4 cycles, `d_waitrequest` low only on the 4th cycle.
- Timeout: TIMEOUT=8, waitrequest stuck high → strobes drop after 8 stall cycles, `bus_error`=1 until reset, and no readdatavalid occurs.
- Reset asserted in RESP → next cycle all strobes are 0, both readdatavalids are 0, and the arbiter is in IDLE.
